matrix_3x3_gen: RTL and testbench
=================================

# matrix_3x3_gen

Downstream neighbour of the video line-delay buffer in the DVP video-processing chain. Consumes a raster pixel stream with vsync/href/clken qualifiers and produces a 3x3 pixel neighbourhood per accepted pixel, plus matching delayed sync qualifiers, for Sobel/median/Gaussian filter stages. Internally holds two previous lines in one dual-row line memory. Rows/columns outside the image read as zero.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_H_DISP, 1280, active pixels per line (line memory depth)
- clk  in  1  pixel clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- per_frame_vsync  in  1  frame sync, high during frame
- per_frame_href  in  1  line valid, high during active line
- per_frame_clken  in  1  pixel strobe; pixel accepted when href && clken
- per_img_data  in  DATA_WIDTH  input pixel
- matrix_frame_vsync  out  1  vsync delayed 2 cycles
- matrix_frame_href  out  1  href delayed 2 cycles
- matrix_frame_clken  out  1  clken delayed 2 cycles
- matrix_p11..p13, p21..p23, p31..p33  out  DATA_WIDTH each  window; row 1 oldest line, column 3 newest pixel

## Operation
- Accept = per_frame_href && per_frame_clken.
- Column counter col: increments on accept, wraps IMG_H_DISP-1 → 0; forced to 0 while href low.
- Line counter lcnt (2 bits, saturating at 2): increments on href falling edge; cleared on vsync rising edge.
- Line memory: IMG_H_DISP entries × 2·DATA_WIDTH, entry = {line y-2, line y-1}. On accept at address col: read old entry (read-before-write, registered, 1 cycle), write {old[line y-1 half], per_img_data}.
- Row taps (cycle after accept): r1 = old y-2 half, r2 = old y-1 half, r3 = pixel registered alongside. Masking: lcnt==0 → r1=r2=0; lcnt==1 → r1=0.
- Window shift (next cycle, on delayed accept): each row shifts left (pX1←pX2, pX2←pX3, pX3←rX).
- While delayed href low, all nine window registers clear to 0, so first pixel of a line has p11/p12/p21/p22/p31/p32 = 0.
- Sync outputs: 2-stage pipeline of vsync/href/clken, no gating.
- Line-memory contents not reset; masking hides stale data after reset.

## Timing
- Reset (sync, rst=1 at edge): all outputs 0, col=0, lcnt=0, pipelines cleared. Reset mid-line: stream restarts; next frame (vsync rise) produces correct windows; partial-frame windows undefined but masked per lcnt.
- Latency: pixel accepted at cycle N appears as p33 at cycle N+2 with matrix_frame_clken=1 at N+2.
- clken gaps: window and taps hold; no bubbles inserted; output clken mirrors input gap pattern.
- href held high beyond IMG_H_DISP accepts: col wraps to 0, memory overwritten in order (defined, not an error).
- vsync rise concurrent with href fall: lcnt cleared (vsync wins).
- Window centre p22 = pixel (x-1, y-1) relative to newest pixel p33 = (x, y).

## Structure
- Shared video package: DATA_WIDTH default, sync-delay depth constant (2), lcnt width.
- One sub-module: line_mem_rbw — single-port-address, read-before-write RAM, registered read, no reset on array, width 2·DATA_WIDTH, depth IMG_H_DISP.
- Top: counters, masking, window shift registers, sync delay pipeline.

## Test plan
- Reset: rst=1 two cycles with random inputs → all outputs 0; deassert, idle → stay 0.
- IMG_H_DISP=4, 4×4 frame, pixel = 16·y + x, clken always 1 → line 0 windows have rows 1,2 = 0; at y=2,x=2 window = {0x00,0x01,0x02; 0x10,0x11,0x12; 0x20,0x21,0x22}, 2 cycles after input 0x22.
- First column: at y=3,x=0 → p33=0x30, p23=0x20, p13=0x10, columns 1–2 all 0.
- clken toggling 1/0 → outputs change only 2 cycles after each accept; window values identical to continuous case; output clken = input clken delayed 2.
- Second frame after vsync low/high → lcnt reset; line 0 rows 1,2 masked to 0 despite stale memory.
- rst pulse mid-line 2 then new frame → outputs 0 during reset, next frame windows match golden model.

Source files
------------

// File: rtl/matrix_3x3_gen_pkg.sv
// Shared video-chain definitions: default pixel width, sync pipeline depth,
// line counter sizing and the bundled sync qualifier type.
package matrix_3x3_gen_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SYNC_DLY       = 2;
    localparam int LCNT_W         = 2;
    localparam logic [LCNT_W-1:0] LCNT_MAX = 2'd2;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    // A pixel is consumed only when the line is valid and the strobe is high.
    function automatic logic accept(input sync_t s);
        return s.href & s.clken;
    endfunction

endpackage

// File: rtl/line_mem_rbw.sv
// Dual-row line memory: each entry holds {line y-2, line y-1} for one column.
// An enabled access returns the old entry one cycle later and shifts the entry
// so the newest pixel becomes the y-1 half. The array itself is never reset.
module line_mem_rbw #(
    parameter int DW    = 8,
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  logic            clk,
    input  logic            en,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   din,
    output logic [2*DW-1:0] rdata
);

    logic [2*DW-1:0] mem [DEPTH];
    logic [2*DW-1:0] rd_q;

    // Read the old entry and write the shifted entry in the same cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            rd_q      <= mem[addr];
            mem[addr] <= {mem[addr][DW-1:0], din};
        end
    end

    assign rdata = rd_q;

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator for a raster pixel stream. Two previous lines
// live in line_mem_rbw; the window is three 3-deep shift registers fed by
// masked row taps, and the sync qualifiers ride a matching 2-stage pipeline.
module matrix_3x3_gen
    import matrix_3x3_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_H_DISP = 1280
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_data,
    output logic                  matrix_frame_vsync,
    output logic                  matrix_frame_href,
    output logic                  matrix_frame_clken,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33
);

    localparam int AW = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;

    sync_t                           sync_in;
    sync_t [SYNC_DLY:1]              sync_pipe_q, sync_pipe_d;
    logic                            acc, acc_d1, vsync_rise, href_fall;
    logic [AW-1:0]                   col_q, col_d;
    logic [LCNT_W-1:0]               lcnt_q, lcnt_d;
    logic [DATA_WIDTH-1:0]           pix_q, pix_d;
    logic [2*DATA_WIDTH-1:0]         mem_rd;
    logic [2:0][DATA_WIDTH-1:0]      tap;
    // win[row][col]: row 0 = oldest line, col 2 = newest pixel
    logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;

    assign sync_in = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};

    // Memory is idle during reset so a reset never disturbs stored lines.
    line_mem_rbw #(
        .DW    (DATA_WIDTH),
        .DEPTH (IMG_H_DISP),
        .AW    (AW)
    ) u_line_mem (
        .clk   (clk),
        .en    (acc & ~rst),
        .addr  (col_q),
        .din   (per_img_data),
        .rdata (mem_rd)
    );

    // Next-state: counters, sync pipeline, tap masking and window shift.
    always_comb begin
        acc        = accept(sync_in);
        acc_d1     = accept(sync_pipe_q[1]);
        vsync_rise = sync_in.vsync & ~sync_pipe_q[1].vsync;
        href_fall  = ~sync_in.href & sync_pipe_q[1].href;

        col_d = col_q;
        if (!per_frame_href)
            col_d = '0;
        else if (acc)
            col_d = (col_q == AW'(IMG_H_DISP - 1)) ? '0 : col_q + AW'(1);

        // vsync rise wins over a simultaneous line end
        lcnt_d = lcnt_q;
        if (vsync_rise)
            lcnt_d = '0;
        else if (href_fall && lcnt_q != LCNT_MAX)
            lcnt_d = lcnt_q + LCNT_W'(1);

        sync_pipe_d = {sync_pipe_q[SYNC_DLY-1:1], sync_in};
        pix_d       = acc ? per_img_data : pix_q;

        // Lines that do not exist yet in this frame read as zero, which also
        // hides whatever the memory held from a previous frame.
        tap[0] = (lcnt_q >= LCNT_W'(2)) ? mem_rd[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        tap[1] = (lcnt_q >= LCNT_W'(1)) ? mem_rd[DATA_WIDTH-1:0] : '0;
        tap[2] = pix_q;

        win_d = win_q;
        if (!sync_pipe_q[1].href) begin
            win_d = '0;
        end else if (acc_d1) begin
            for (int r = 0; r < 3; r++)
                win_d[r] = {tap[r], win_q[r][2], win_q[r][1]};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            lcnt_q      <= '0;
            sync_pipe_q <= '0;
            pix_q       <= '0;
            win_q       <= '0;
        end else begin
            col_q       <= col_d;
            lcnt_q      <= lcnt_d;
            sync_pipe_q <= sync_pipe_d;
            pix_q       <= pix_d;
            win_q       <= win_d;
        end
    end

    assign matrix_frame_vsync = sync_pipe_q[SYNC_DLY].vsync;
    assign matrix_frame_href  = sync_pipe_q[SYNC_DLY].href;
    assign matrix_frame_clken = sync_pipe_q[SYNC_DLY].clken;

    assign matrix_p11 = win_q[0][0];
    assign matrix_p12 = win_q[0][1];
    assign matrix_p13 = win_q[0][2];
    assign matrix_p21 = win_q[1][0];
    assign matrix_p22 = win_q[1][1];
    assign matrix_p23 = win_q[1][2];
    assign matrix_p31 = win_q[2][0];
    assign matrix_p32 = win_q[2][1];
    assign matrix_p33 = win_q[2][2];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen with a 4-pixel line and 4-line frames,
// pixel value = base + 16*y + x, windows checked against a zero-padded model.
module tb_matrix_3x3_gen;

    localparam int W = 4;
    // {vsync, href, clken} input patterns
    localparam logic [2:0] IDLE = 3'b000, VS = 3'b100, VSC = 3'b101, ACC = 3'b111, GAP = 3'b110;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs, hr, ce;
    logic [7:0] din;
    logic       o_vs, o_hr, o_ce;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    typedef struct {
        logic [71:0] w;
        int          x;
        int          y;
        int          base;
    } exp_t;

    exp_t        q[$];
    exp_t        e_m;
    int          tests = 0;
    int          fails = 0;
    bit          sb_en = 1'b0;
    logic [71:0] cap22, cap03;
    logic [2:0]  h1 = '0, h2 = '0;
    logic [71:0] win;
    logic [2:0]  sync_o;

    assign win    = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
    assign sync_o = {o_vs, o_hr, o_ce};

    always #5 clk = ~clk;

    matrix_3x3_gen #(.DATA_WIDTH(8), .IMG_H_DISP(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .per_frame_vsync    (vs),
        .per_frame_href     (hr),
        .per_frame_clken    (ce),
        .per_img_data       (din),
        .matrix_frame_vsync (o_vs),
        .matrix_frame_href  (o_hr),
        .matrix_frame_clken (o_ce),
        .matrix_p11         (p11),
        .matrix_p12         (p12),
        .matrix_p13         (p13),
        .matrix_p21         (p21),
        .matrix_p22         (p22),
        .matrix_p23         (p23),
        .matrix_p31         (p31),
        .matrix_p32         (p32),
        .matrix_p33         (p33)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Zero-padded 3x3 neighbourhood ending at pixel (x, y).
    function automatic logic [71:0] exp_win(input int x, input int y, input int base);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int ly;
                int lx;
                logic [7:0] v;
                ly = y - 2 + r;
                lx = x - 2 + c;
                v  = (ly < 0 || lx < 0) ? 8'h00 : 8'(base + 16 * ly + lx);
                w  = {w[63:0], v};
            end
        end
        return w;
    endfunction

    task automatic step(input logic [2:0] s, input logic [7:0] d);
        {vs, hr, ce} = s;
        din          = d;
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int x, input int y, input int base);
        exp_t e;
        e.w    = exp_win(x, y, base);
        e.x    = x;
        e.y    = y;
        e.base = base;
        q.push_back(e);
        step(ACC, 8'(base + 16 * y + x));
    endtask

    // abort_x >= 0: pulse reset while accepting pixel abort_x of line 2.
    task automatic send_frame(input int base, input bit gap, input int abort_x);
        step(VS, 8'h00);
        step(VS, 8'h00);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < W; x++) begin
                if (abort_x >= 0 && y == 2 && x == abort_x) begin
                    sb_en = 1'b0;
                    rst   = 1'b1;
                    step(ACC, 8'h5A);
                    rst   = 1'b0;
                    @(negedge clk);
                    chk("rst_mid_win", win, 72'h0);
                    chk("rst_mid_sync", 72'(sync_o), 72'h0);
                    q.delete();
                    @(posedge clk);
                    #1;
                    step(IDLE, 8'h00);
                    step(IDLE, 8'h00);
                    step(IDLE, 8'h00);
                    sb_en = 1'b1;
                    return;
                end
                px(x, y, base);
                if (gap) step(GAP, 8'hEE);
            end
            step(VSC, 8'h00);
            step(VS, 8'h00);
            step(VS, 8'h00);
        end
        step(IDLE, 8'h00);
        step(IDLE, 8'h00);
    endtask

    // Scoreboard: sync outputs are inputs delayed two cycles; each output
    // accept pops the oldest expected window.
    always @(negedge clk) begin
        if (sb_en) begin
            chk("sync_dly2", 72'(sync_o), 72'(h2));
            if (o_hr && o_ce) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 72'(q.size()), 72'd1);
                end else begin
                    e_m = q.pop_front();
                    chk($sformatf("win_b%0h_y%0dx%0d", e_m.base, e_m.y, e_m.x), win, e_m.w);
                    if (e_m.base == 0 && e_m.y == 2 && e_m.x == 2) cap22 = win;
                    if (e_m.base == 0 && e_m.y == 3 && e_m.x == 0) cap03 = win;
                end
            end
        end
        h2 = h1;
        h1 = {vs, hr, ce};
    end

    initial begin
        rst = 1'b1;
        step(3'($urandom), 8'($urandom));
        @(negedge clk);
        chk("rst_win_0", win, 72'h0);
        chk("rst_sync_0", 72'(sync_o), 72'h0);
        @(posedge clk);
        #1;
        step(3'($urandom), 8'($urandom));
        @(negedge clk);
        chk("rst_win_1", win, 72'h0);
        chk("rst_sync_1", 72'(sync_o), 72'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(IDLE, 8'h00);
        step(IDLE, 8'h00);
        step(IDLE, 8'h00);
        @(negedge clk);
        chk("idle_win", win, 72'h0);
        chk("idle_sync", 72'(sync_o), 72'h0);
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // continuous clken
        cap22 = 'x;
        cap03 = 'x;
        send_frame(0, 1'b0, -1);
        chk("hand_y2x2", cap22, {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22});
        chk("hand_y3x0", cap03, {8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h30});

        // clken toggling: identical windows expected
        cap22 = 'x;
        cap03 = 'x;
        send_frame(0, 1'b1, -1);
        chk("gap_y2x2", cap22, {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22});
        chk("gap_y3x0", cap03, {8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h30});

        // new frame with different pixels: stale memory must stay masked
        send_frame(8'h80, 1'b0, -1);

        // reset mid line 2, then a clean frame
        send_frame(8'h40, 1'b0, 2);
        send_frame(8'h40, 1'b1, -1);

        for (int i = 0; i < 4; i++) step(IDLE, 8'h00);
        chk("sb_drain", 72'(q.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
